// File: rtl/pool_relu_stream_if.sv
// Stream bus for the pooling/ReLU stage: pixel input, per-frame controls,
// and the pooled output with its valid and frame-done strobes.
interface pool_relu_stream_if #(
    parameter int DATA_BITS = 12,
    parameter int CHANNELS  = 3
);
    logic                          valid_in;
    logic [CHANNELS*DATA_BITS-1:0] data_in;
    logic                          mode_avg;
    logic                          relu_en;
    logic [CHANNELS*DATA_BITS-1:0] data_out;
    logic                          valid_out;
    logic                          frame_done;

    // Pixel source / result sink side
    modport master (
        output valid_in, data_in, mode_avg, relu_en,
        input  data_out, valid_out, frame_done
    );

    // Pooling stage side
    modport slave (
        input  valid_in, data_in, mode_avg, relu_en,
        output data_out, valid_out, frame_done
    );
endinterface

// File: rtl/pool_relu_stream.sv
// Streaming 2x2 / stride-2 max or average pooling followed by optional ReLU.
// Pixels arrive in raster order with arbitrary gaps; every valid cycle is
// accepted. One pooled pixel leaves per 2x2 window, one cycle after the
// window's bottom-right pixel is accepted.

// One channel: horizontal pair, line buffer of pairs, vertical combine.
module pool_relu_lane #(
    parameter int DATA_BITS = 12,
    parameter int DEPTH     = 12,
    parameter int IDX_BITS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold_en,
    input  logic                        wr_en,
    input  logic                        out_en,
    input  logic [IDX_BITS-1:0]         idx,
    input  logic                        mode_avg,
    input  logic                        relu,
    input  logic signed [DATA_BITS-1:0] sample,
    output logic signed [DATA_BITS-1:0] result
);
    logic signed [DATA_BITS-1:0] held;
    logic signed [DATA_BITS:0]   line_buf [DEPTH];
    logic signed [DATA_BITS:0]   pair;
    logic signed [DATA_BITS:0]   above;
    logic signed [DATA_BITS:0]   vmax;
    logic signed [DATA_BITS+1:0] vsum;
    logic signed [DATA_BITS-1:0] pooled;

    // Horizontal pair (held even-col sample with current odd-col sample),
    // then vertical combine with the pair stored on the even row.
    always_comb begin
        if (mode_avg)
            pair = (DATA_BITS+1)'(held) + (DATA_BITS+1)'(sample);
        else
            pair = (held > sample) ? (DATA_BITS+1)'(held) : (DATA_BITS+1)'(sample);
        above  = line_buf[idx];
        vmax   = (pair > above) ? pair : above;
        vsum   = (DATA_BITS+2)'(pair) + (DATA_BITS+2)'(above);
        // Max of in-range samples and floor of a 4-sample mean both fit DATA_BITS
        pooled = mode_avg ? DATA_BITS'(vsum >>> 2) : DATA_BITS'(vmax);
        if (relu && pooled[DATA_BITS-1])
            pooled = '0;
    end

    // Even-column sample waits here for its odd-column partner
    always_ff @(posedge clk) begin
        if (hold_en)
            held <= sample;
    end

    // Even-row pairs are parked until the odd row below consumes them
    always_ff @(posedge clk) begin
        if (wr_en)
            line_buf[idx] <= pair;
    end

    // Registered result, held until the next pooled pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result <= '0;
        else if (out_en)
            result <= pooled;
    end
endmodule

module pool_relu_stream #(
    parameter int DATA_BITS = 12,
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24,
    parameter int COL_BITS  = 5,
    parameter int ROW_BITS  = 5
) (
    input  logic                clk,
    input  logic                rst,
    pool_relu_stream_if.slave   bus
);
    localparam int HALF_W   = IN_WIDTH / 2;
    localparam int IDX_BITS = (COL_BITS > 1) ? COL_BITS - 1 : 1;

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                mode_q;
    logic                relu_q;
    logic                first;
    logic                col_last;
    logic                row_last;
    logic                mode;
    logic                relu;
    logic                hold_en;
    logic                wr_en;
    logic                out_en;
    logic [IDX_BITS-1:0] idx;
    logic                valid_q;
    logic                done_q;
    logic [CHANNELS-1:0][DATA_BITS-1:0] lane_out;

    // Position decode; controls of pixel (0,0) apply to its own frame at once
    always_comb begin
        first    = (col == '0) && (row == '0);
        col_last = (col == COL_BITS'(IN_WIDTH - 1));
        row_last = (row == ROW_BITS'(IN_HEIGHT - 1));
        mode     = first ? bus.mode_avg : mode_q;
        relu     = first ? bus.relu_en  : relu_q;
        hold_en  = bus.valid_in && !col[0];
        wr_en    = bus.valid_in &&  col[0] && !row[0];
        out_en   = bus.valid_in &&  col[0] &&  row[0];
        idx      = IDX_BITS'(col >> 1);
    end

    // Raster counters and per-frame control latch, advanced on accepted pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            mode_q <= 1'b0;
            relu_q <= 1'b0;
        end else if (bus.valid_in) begin
            if (first) begin
                mode_q <= bus.mode_avg;
                relu_q <= bus.relu_en;
            end
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output strobes, aligned with the registered lane results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= out_en;
            done_q  <= out_en && row_last && col_last;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        pool_relu_lane #(
            .DATA_BITS (DATA_BITS),
            .DEPTH     (HALF_W),
            .IDX_BITS  (IDX_BITS)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .hold_en  (hold_en),
            .wr_en    (wr_en),
            .out_en   (out_en),
            .idx      (idx),
            .mode_avg (mode),
            .relu     (relu),
            .sample   (bus.data_in[k*DATA_BITS +: DATA_BITS]),
            .result   (lane_out[k])
        );
    end

    assign bus.data_out   = lane_out;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_pool_relu_stream.sv
// Directed bench for pool_relu_stream (8-bit, 2 channels, 4x4 frames).
// A reference model computes each 2x2 window from stored pixels and queues
// the expected result with its due time; a monitor pops and compares.
module tb_pool_relu_stream;
    typedef struct {
        logic [15:0] data;
        logic        fd;
        time         due;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t q[$];

    logic signed [7:0] pix [2][4][4];
    int   mr, mc;
    logic lm, lr;

    int ext [4][4] = '{
        '{-128, -128,  127,  127},
        '{-128, -128,  127,  127},
        '{ 127,  127, -128,  127},
        '{-128, -128, -128,  127}
    };

    pool_relu_stream_if #(.DATA_BITS(8), .CHANNELS(2)) bus ();

    pool_relu_stream #(
        .DATA_BITS (8),
        .CHANNELS  (2),
        .IN_WIDTH  (4),
        .IN_HEIGHT (4),
        .COL_BITS  (2),
        .ROW_BITS  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        lm = 1'b0;
        lr = 1'b0;
    endtask

    // Drive one pixel for one cycle, update the model, then idle 'gap' cycles
    task automatic px(input int v0, input int v1, input logic m, input logic r, input int gap);
        logic signed [7:0] s0, s1;
        int   a, b, c, d, res;
        exp_t e;
        @(negedge clk);
        s0 = 8'(v0);
        s1 = 8'(v1);
        bus.valid_in = 1'b1;
        bus.data_in  = {s1, s0};
        bus.mode_avg = m;
        bus.relu_en  = r;
        if (mr == 0 && mc == 0) begin
            lm = m;
            lr = r;
        end
        pix[0][mr][mc] = s0;
        pix[1][mr][mc] = s1;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            e.data = '0;
            for (int ch = 0; ch < 2; ch++) begin
                a = pix[ch][mr-1][mc-1];
                b = pix[ch][mr-1][mc];
                c = pix[ch][mr][mc-1];
                d = pix[ch][mr][mc];
                if (lm) begin
                    res = (a + b + c + d) >>> 2;
                end else begin
                    res = a;
                    if (b > res) res = b;
                    if (c > res) res = c;
                    if (d > res) res = d;
                end
                if (lr && res < 0) res = 0;
                e.data[ch*8 +: 8] = 8'(res);
            end
            e.fd  = (mr == 3 && mc == 3);
            e.due = $time + 10;
            q.push_back(e);
        end
        if (mc == 3) begin
            mc = 0;
            mr = (mr == 3) ? 0 : mr + 1;
        end else begin
            mc++;
        end
        repeat (gap) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
    endtask

    // kind 0: ramp, 1: extremes, 2: random. Mode switches from m0 to m1 at pixel 5.
    task automatic frame(input int kind, input logic m0, input logic m1, input logic r, input int maxgap);
        int v0, v1, rr, cc;
        for (int i = 0; i < 16; i++) begin
            rr = i / 4;
            cc = i % 4;
            case (kind)
                0:       begin v0 = 4*rr + cc;    v1 = -(4*rr + cc); end
                1:       begin v0 = ext[rr][cc];  v1 = -ext[rr][cc]; end
                default: begin v0 = int'($urandom_range(255, 0)); v1 = int'($urandom_range(255, 0)); end
            endcase
            px(v0, v1, (i < 5) ? m0 : m1, r, int'($urandom_range(maxgap, 0)));
        end
    endtask

    // Output monitor: every valid_out must match the next queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (q.size() > 0 && q[0].due < $time) begin
                    chk("out_time_missed", 32'($time), 32'(q[0].due));
                    void'(q.pop_front());
                end
                if (bus.valid_out) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", {31'b0, bus.valid_out}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("data_out",   {16'b0, bus.data_out}, {16'b0, e.data});
                        chk("frame_done", {31'b0, bus.frame_done}, {31'b0, e.fd});
                        chk("latency",    32'($time), 32'(e.due));
                    end
                end else begin
                    chk("frame_done_idle", {31'b0, bus.frame_done}, 32'd0);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.mode_avg = 1'b0;
        bus.relu_en  = 1'b0;
        model_reset();
        idle(2);
        chk("rst_data_out",   {16'b0, bus.data_out}, 32'd0);
        chk("rst_valid_out",  {31'b0, bus.valid_out}, 32'd0);
        chk("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        frame(0, 1'b0, 1'b0, 1'b0, 0);   // max, relu off
        frame(0, 1'b0, 1'b0, 1'b1, 0);   // max, relu on
        frame(0, 1'b1, 1'b1, 1'b0, 0);   // avg, relu off
        frame(0, 1'b0, 1'b0, 1'b0, 3);   // max with gaps, two frames back-to-back
        frame(0, 1'b0, 1'b0, 1'b0, 3);
        frame(1, 1'b1, 1'b1, 1'b0, 0);   // avg extremes
        frame(1, 1'b0, 1'b0, 1'b1, 1);   // max extremes, relu on
        frame(2, 1'b1, 1'b1, 1'b1, 2);   // random avg, relu on
        frame(2, 1'b0, 1'b1, 1'b0, 2);   // random max, mid-frame mode change ignored
        idle(3);

        // Mid-frame reset: partial frame discarded, outputs cleared
        for (int i = 0; i < 6; i++) px(i, -i, 1'b1, 1'b1, 0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_data_out",   {16'b0, bus.data_out}, 32'd0);
        chk("midrst_valid_out",  {31'b0, bus.valid_out}, 32'd0);
        chk("midrst_frame_done", {31'b0, bus.frame_done}, 32'd0);
        rst = 1'b0;

        frame(0, 1'b0, 1'b1, 1'b0, 0);   // latched max despite toggle at pixel 5
        frame(0, 1'b1, 1'b1, 1'b0, 0);   // next frame takes avg
        idle(4);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
